dm_bridge: RTL and testbench
============================

# dm_bridge

Data-side memory bridge between the single-cycle CPU core's load/store path and an external handshake memory with variable latency. It replaces the zero-latency data memory, converting each CPU load or store into a req/ack transaction. It freezes the core with `stall` until the access completes, times out, or is rejected.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles in ACCESS without `mem_ack` before the access is aborted (legal range 1..255).
- `ERR_DATA`, default 32'hDEAD_BEEF: value returned on `cpu_rdata` for an aborted load.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_address` in 32: byte address from the ALU result.
- `cpu_wdata` in 32: store data (rt value).
- `cpu_mem_write` in 1: current instruction is a store.
- `cpu_mem_read` in 1: current instruction is a load.
- `cpu_rdata` out 32: load data to the writeback mux.
- `stall` out 1: high means hold the PC and suppress GPR and other writes this cycle.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 means write, 0 means read.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid when `mem_ack` is high.
- `mem_ack` in 1: single-cycle completion pulse.
- `bus_error` out 1: sticky flag for a misaligned or timed-out access; cleared only by `reset`.

## Operation
State machine with three states: IDLE, ACCESS, DONE.
- **IDLE:**
  - `stall` = `cpu_mem_read | cpu_mem_write`, combinational in the same cycle.
  - On a request with `cpu_address[1:0] == 0`:
    - Latch address, wdata and `mem_we = cpu_mem_write`.
    - Clear the wait counter.
    - Go to ACCESS.
  - On a misaligned request:
    - No external access.
    - Set `bus_error`.
    - `cpu_rdata` = `ERR_DATA`.
    - Go to DONE.
  - If both read and write are asserted, the access is treated as a write.
- **ACCESS:**
  - `mem_req` = 1 and `stall` = 1.
  - Outputs are driven from the latched registers and stay stable until ack.
  - On `mem_ack`:
    - Register `mem_rdata` into `cpu_rdata` (read only; a write leaves `cpu_rdata` unchanged).
    - Go to DONE.
  - Otherwise, if the wait counter equals `TIMEOUT_CYCLES - 1`:
    - Drop `mem_req`.
    - Set `bus_error`.
    - `cpu_rdata` = `ERR_DATA`.
    - Go to DONE.
  - Otherwise, increment the counter.
  - If ack and timeout occur in the same cycle, ack wins.
- **DONE:**
  - `stall` = 0, so the core commits the instruction on this edge using `cpu_rdata`.
  - Request inputs still belong to the finishing instruction and are ignored.
  - Always go to IDLE.
- `mem_ack` outside ACCESS is ignored.
- `cpu_rdata` holds its value until the next load completes or aborts.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
  - `cpu_rdata` 0, `bus_error` 0, wait counter 0.
  - `stall` follows the combinational IDLE rule.
- Minimum access (ack in the first ACCESS cycle) takes 3 cycles: IDLE (stall), ACCESS (stall, ack), DONE (commit).
- With N wait cycles before ack, the instruction takes 3 + N cycles.
- Timeout abort: the instruction takes `TIMEOUT_CYCLES` + 2 cycles.
- Back-to-back memory instructions: DONE, then IDLE (new request detected), so there is no extra bubble beyond the 3-cycle minimum.
- Non-memory instructions pass through IDLE with `stall` = 0 at full rate.
- Reset asserted mid-ACCESS:
  - `mem_req` drops asynchronously.
  - The transaction is abandoned and any later `mem_ack` is ignored.

## Structure
- Shared package `dm_bridge_pkg`: state enum (IDLE/ACCESS/DONE), the alignment mask constant 2'b00, and the default `ERR_DATA`.
- One sub-module, `wait_timer`: clear/enable counter with an `expired` output compared against `TIMEOUT_CYCLES - 1`, width `$clog2(TIMEOUT_CYCLES+1)`.
- The FSM and datapath registers stay in `dm_bridge`.

## Test plan
- Aligned load to 0x0000_0010, memory acks on the 1st ACCESS cycle with 0x1234_5678:
  - `stall` is high for 2 cycles.
  - `cpu_rdata` = 0x1234_5678 in DONE.
  - `bus_error` stays 0.
- Store of 0xCAFE_F00D to 0x0000_0020, ack after 4 wait cycles:
  - `mem_we` = 1 and `mem_wdata` stable through ACCESS.
  - `stall` is high for 6 cycles.
  - `cpu_rdata` is unchanged.
- Load to 0x0000_0013:
  - `mem_req` never rises.
  - `bus_error` = 1 and `cpu_rdata` = 0xDEAD_BEEF.
  - `stall` is high for 1 cycle, then DONE.
- Load with no ack, `TIMEOUT_CYCLES` = 16:
  - `mem_req` is high for exactly 16 cycles.
  - `bus_error` = 1 and `cpu_rdata` = 0xDEAD_BEEF.
  - A late `mem_ack` afterwards has no effect.
- Ack arrives in the same cycle as the 16th wait cycle: data is accepted and `bus_error` stays 0.
- `reset` pulsed during ACCESS:
  - `mem_req` drops immediately and `bus_error` = 0.
  - The next load completes normally in 3 cycles.

Source files
------------

// File: rtl/dm_bridge_pkg.sv
// dm_bridge_pkg: definitions shared by the data-side memory bridge.
//   state_t          - bridge FSM states (IDLE / ACCESS / DONE)
//   ALIGN_OK         - value the low two address bits must hold for a word access
//   DEFAULT_ERR_DATA - load data returned when an access is aborted
//   word_align()     - clears the byte-offset bits of an address
package dm_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0]  ALIGN_OK         = 2'b00;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_bridge_if.sv
// dm_bridge_if: CPU load/store path plus external memory handshake.
//   CPU side : cpu_address, cpu_wdata, cpu_mem_write, cpu_mem_read (to bridge)
//              cpu_rdata, stall, bus_error (from bridge)
//   Mem side : mem_req, mem_we, mem_addr, mem_wdata (from bridge)
//              mem_rdata, mem_ack (to bridge)
//
// Handshake: mem_req is a level that stays high, with mem_we/mem_addr/mem_wdata
// held stable, until the memory answers. mem_ack is a one-cycle pulse; the
// transfer completes on the rising edge where mem_req and mem_ack are both high,
// and mem_rdata is only meaningful on that edge. The bridge may withdraw
// mem_req without an ack (timeout or reset); an ack seen while mem_req is low
// belongs to no transfer and is ignored.
//
// Modports: slave = the bridge, master = the core + memory environment.
interface dm_bridge_if;

  logic [31:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic        cpu_mem_write;
  logic        cpu_mem_read;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        bus_error;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_address, cpu_wdata, cpu_mem_write, cpu_mem_read,
    input  mem_rdata, mem_ack,
    output cpu_rdata, stall, bus_error,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_address, cpu_wdata, cpu_mem_write, cpu_mem_read,
    output mem_rdata, mem_ack,
    input  cpu_rdata, stall, bus_error,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_bridge_wait_timer.sv
// wait_timer: counts cycles spent waiting for a memory ack.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : reset the count to zero (wins over i_enable)
//   i_enable     : advance the count by one
//   o_expired    : count has reached TIMEOUT_CYCLES - 1
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/dm_bridge.sv
// dm_bridge: turns each single-cycle CPU load/store into a req/ack transaction
// on a variable-latency memory, freezing the core with stall until the access
// completes, times out, or is rejected as misaligned.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : dm_bridge_if.slave (CPU path and memory handshake)
//   o_dbg_state  : current FSM state, for observation only
module dm_bridge
  import dm_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic         clock,
  input  logic         reset,
  dm_bridge_if.slave   bus,
  output state_t       o_dbg_state
);

  state_t      r_state;
  state_t      w_next_state;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_error;

  logic        w_request;
  logic        w_aligned;
  logic        w_stall;
  logic        w_req;
  logic        w_latch;
  logic        w_timer_clear;
  logic        w_timer_enable;
  logic        w_timer_expired;
  logic        w_ack_done;
  logic        w_abort;
  logic        w_abort_is_load;

  assign w_request = bus.cpu_mem_read | bus.cpu_mem_write;
  assign w_aligned = (bus.cpu_address[1:0] == ALIGN_OK);

  wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_expired (w_timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_stall         = 1'b0;
    w_req           = 1'b0;
    w_latch         = 1'b0;
    w_timer_clear   = 1'b0;
    w_timer_enable  = 1'b0;
    w_ack_done      = 1'b0;
    w_abort         = 1'b0;
    w_abort_is_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_request;
        if (w_request) begin
          if (w_aligned) begin
            w_latch       = 1'b1;
            w_timer_clear = 1'b1;
            w_next_state  = ST_ACCESS;
          end else begin
            w_abort         = 1'b1;
            // read+write together counts as a store
            w_abort_is_load = ~bus.cpu_mem_write;
            w_next_state    = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        // ack is checked first so a reply on the last wait cycle is accepted
        if (bus.mem_ack) begin
          w_ack_done   = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_timer_expired) begin
          w_abort         = 1'b1;
          w_abort_is_load = ~r_we;
          w_next_state    = ST_DONE;
        end else begin
          w_timer_enable = 1'b1;
        end
      end
      ST_DONE: begin
        // inputs still describe the instruction being committed; ignore them
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_latch) begin
        r_we    <= bus.cpu_mem_write;
        r_addr  <= word_align(bus.cpu_address);
        r_wdata <= bus.cpu_wdata;
      end
      if (w_ack_done && !r_we) begin
        r_rdata <= bus.mem_rdata;
      end
      if (w_abort) begin
        r_bus_error <= 1'b1;
        // stores have no load result, so cpu_rdata keeps the last load value
        if (w_abort_is_load) begin
          r_rdata <= ERR_DATA;
        end
      end
    end
  end

  // mem_req decodes straight from the state register so reset withdraws it
  // immediately rather than at the next edge.
  assign bus.mem_req   = w_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_rdata = r_rdata;
  assign bus.stall     = w_stall;
  assign bus.bus_error = r_bus_error;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dm_bridge.sv
module tb_dm_bridge;
  import dm_bridge_pkg::*;

  logic   clock;
  logic   reset;
  state_t dbg_state;

  dm_bridge_if bus ();

  dm_bridge #(
    .TIMEOUT_CYCLES (16),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge with the bridge in IDLE. Presents one
  // memory instruction, plays the memory (ack after ack_wait ACCESS cycles,
  // never if negative) and checks the result in the DONE cycle.
  task automatic run_txn(input string tag, input logic we, input logic both,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mdata, input int ack_wait,
                         input int exp_stall, input int exp_req,
                         input logic [31:0] exp_rdata, input logic exp_berr);
    int stall_n = 0;
    int req_n   = 0;
    int cyc     = 0;
    bit done    = 0;
    bit stable  = 1;
    logic [31:0] exp_v;
    exp_q.push_back(exp_rdata);
    bus.cpu_address   = addr;
    bus.cpu_wdata     = wdata;
    bus.cpu_mem_write = we;
    bus.cpu_mem_read  = !we | both;
    while (!done && cyc < 100) begin
      @(negedge clock);
      bus.mem_ack = 1'b0;
      if (bus.stall) stall_n++;
      if (bus.mem_req) begin
        if (bus.mem_addr !== {addr[31:2], 2'b00} || bus.mem_we !== we ||
            (we && bus.mem_wdata !== wdata)) stable = 0;
        if (req_n == ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mdata;
        end
        req_n++;
      end
      if (!bus.stall) begin
        done  = 1;
        exp_v = exp_q.pop_front();
        chk({tag, "_rdata"}, bus.cpu_rdata, exp_v);
        chk({tag, "_berr"}, 32'(bus.bus_error), 32'(exp_berr));
        chk({tag, "_state_done"}, 32'(dbg_state), 32'(ST_DONE));
      end
      cyc++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_budget: stall never released after %0d cycles", tag, cyc);
      void'(exp_q.pop_front());
    end
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    if (exp_req > 0) chk({tag, "_req_stable"}, 32'(stable), 32'd1);
    @(posedge clock);
    #1;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_mem_read  = 1'b0;
    bus.mem_ack       = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          ack_wait;
    int          exp_stall;
    int          exp_req;
    logic [31:0] exp_rdata;
    logic        exp_berr;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    int w;
    logic [31:0] d;

    // aligned load, ack on first ACCESS cycle
    vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 2, 1, 32'h1234_5678, 1'b0};
    // store, ack after 4 wait cycles; load data unchanged
    vt[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'hFFFF_0000, 4, 6, 5, 32'h1234_5678, 1'b0};
    // ack on the 16th ACCESS cycle: accepted, no error
    vt[2] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_0001, 15, 17, 16, 32'hA5A5_0001, 1'b0};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h3C3C_7E7E, 2, 4, 3, 32'h3C3C_7E7E, 1'b0};
    // read and write together behave as a store
    vt[4] = '{1'b1, 1'b1, 32'h0000_0030, 32'h0000_0001, 32'h9999_9999, 0, 2, 1, 32'h3C3C_7E7E, 1'b0};
    for (int i = 5; i < 9; i++) begin
      w = int'($urandom_range(0, 12));
      d = $urandom();
      vt[i] = '{1'b0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, d, w, 2 + w, 1 + w, d, 1'b0};
    end
    // misaligned load: rejected without a memory access
    vt[9]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0BAD_0BAD, 0, 1, 0, 32'hDEAD_BEEF, 1'b1};
    // good load afterwards: data returned, error flag stays sticky
    vt[10] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_5555, 1, 3, 2, 32'h0000_5555, 1'b1};
    // no ack: timeout after 16 request cycles
    vt[11] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0, -1, 17, 16, 32'hDEAD_BEEF, 1'b1};

    // ---------------- reset ----------------
    reset             = 1'b1;
    bus.cpu_address   = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_mem_read  = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_ack       = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_bus_error", 32'(bus.bus_error), 32'd0);

    // ---------------- table ----------------
    @(posedge clock);
    #1;
    for (int i = 0; i < NV; i++) begin
      run_txn($sformatf("v%0d", i), vt[i].we, vt[i].both, vt[i].addr, vt[i].wdata,
              vt[i].mdata, vt[i].ack_wait, vt[i].exp_stall, vt[i].exp_req,
              vt[i].exp_rdata, vt[i].exp_berr);
    end

    // ---------------- late ack after timeout, non-memory passthrough ----------------
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    @(negedge clock);
    chk("late_ack_req", 32'(bus.mem_req), 32'd0);
    @(posedge clock);
    #1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("passthru_stall%0d", c), 32'(bus.stall), 32'd0);
    end
    chk("late_ack_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("late_ack_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---------------- reset during ACCESS ----------------
    @(posedge clock);
    #1;
    bus.cpu_address  = 32'h0000_0040;
    bus.cpu_mem_read = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst_req_before", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req_drop", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_berr", 32'(bus.bus_error), 32'd0);
    chk("mid_rst_rdata", bus.cpu_rdata, 32'h0);
    bus.cpu_mem_read = 1'b0;
    @(negedge clock);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("stray_ack_req", 32'(bus.mem_req), 32'd0);
    chk("stray_ack_rdata", bus.cpu_rdata, 32'h0);
    @(posedge clock);
    #1;
    run_txn("post_rst", 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h600D_CAFE, 0, 2, 1,
            32'h600D_CAFE, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
